riscv_str_ops_unit: RTL and testbench

RISCV_STR_OPS_UNIT -- requirements
Module: riscv_str_ops_unit

---
 rtl/riscv_defines.sv | 40 ++++
 rtl/riscv_str_byte_xform.sv | 60 ++++++
 rtl/riscv_str_ops_unit.sv | 123 ++++++++++++
 tb/tb_riscv_str_ops_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
`default_nettype none
// ============================================================================
// Module   : riscv_defines (package)
// Purpose  : Shared opcodes, FSM state encoding and letter-rotation helper
//            for the string-operations unit.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_defines;

    localparam int STR_OP_WIDTH = 3;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER  = 3'b000;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER  = 3'b001;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET   = 3'b010;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13  = 3'b011;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_CAESAR = 3'b100;

    localparam logic [1:0] c_STATE_IDLE = 2'd0;
    localparam logic [1:0] c_STATE_BUSY = 2'd1;
    localparam logic [1:0] c_STATE_DONE = 2'd2;

    // Rotates an ASCII letter within its own case; shift must already be < 26.
    function automatic logic [7:0] str_rot_letter(input logic [7:0] ch,
                                                  input logic [4:0] shift);
        logic       is_up;
        logic       is_lo;
        logic [7:0] base;
        logic [7:0] sum;
        is_up = (ch >= 8'h41) && (ch <= 8'h5A);
        is_lo = (ch >= 8'h61) && (ch <= 8'h7A);
        base  = is_up ? 8'h41 : 8'h61;
        sum   = (ch - base) + {3'b000, shift};
        if (sum >= 8'd26) begin
            sum = sum - 8'd26;
        end
        return (is_up || is_lo) ? (base + sum) : ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_str_byte_xform.sv
`default_nettype none
// ============================================================================
// Module   : riscv_str_byte_xform
// Purpose  : Combinational single-byte transform (case, leet, ROT13, Caesar).
//            Caesar support is compiled only with STR_OPS_CAESAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_str_byte_xform
    import riscv_defines::*;
(
    input  logic [7:0]              i_byte,
    input  logic [STR_OP_WIDTH-1:0] i_op,
    input  logic [4:0]              i_shift,
    output logic [7:0]              o_byte
);

    logic       w_is_upper;
    logic       w_is_lower;
    logic [7:0] w_folded;

    assign w_is_upper = (i_byte >= 8'h41) && (i_byte <= 8'h5A);
    assign w_is_lower = (i_byte >= 8'h61) && (i_byte <= 8'h7A);
    assign w_folded   = i_byte | 8'h20;

`ifdef STR_OPS_CAESAR_EN
    logic [4:0] w_shift_mod;
    assign w_shift_mod = (i_shift >= 5'd26) ? (i_shift - 5'd26) : i_shift;
`else
    logic w_unused_shift;
    assign w_unused_shift = ^i_shift;
`endif

    always_comb begin
        o_byte = i_byte;
        case (i_op)
            STR_OP_UPPER: if (w_is_lower) o_byte = i_byte - 8'd32;
            STR_OP_LOWER: if (w_is_upper) o_byte = i_byte + 8'd32;
            STR_OP_LEET: begin
                if (w_is_upper || w_is_lower) begin
                    case (w_folded)
                        8'h61:   o_byte = 8'h34;
                        8'h65:   o_byte = 8'h33;
                        8'h69:   o_byte = 8'h31;
                        8'h6F:   o_byte = 8'h30;
                        8'h73:   o_byte = 8'h35;
                        8'h74:   o_byte = 8'h37;
                        default: o_byte = i_byte;
                    endcase
                end
            end
            STR_OP_ROT13: o_byte = str_rot_letter(i_byte, 5'd13);
`ifdef STR_OPS_CAESAR_EN
            STR_OP_CAESAR: o_byte = str_rot_letter(i_byte, w_shift_mod);
`endif
            default: o_byte = i_byte;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_str_ops_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_str_ops_unit
// Purpose  : Multi-cycle string transform unit, LANES bytes per cycle with an
//            IDLE/BUSY/DONE handshake. Caesar op enabled by STR_OPS_CAESAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_str_ops_unit
    import riscv_defines::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [DATA_WIDTH-1:0]   operand_a_i,
    input  logic [DATA_WIDTH-1:0]   operand_b_i,
    input  logic                    kill_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [DATA_WIDTH-1:0]   result_o
);

    localparam int c_BYTES     = DATA_WIDTH / 8;
    localparam int c_BEATS     = c_BYTES / LANES;
    localparam int c_LANE_BITS = LANES * 8;
    localparam int c_CNT_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    logic [1:0]              r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [STR_OP_WIDTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [4:0]              r_shift;
    logic [DATA_WIDTH-1:0]   r_result;

    logic                    w_accept;
    logic [4:0]              w_shift_in;
    logic [31:0]             w_bit_off;
    logic [DATA_WIDTH-1:0]   w_beat_src;
    logic [DATA_WIDTH-1:0]   w_beat_mask;
    logic [DATA_WIDTH-1:0]   w_beat_data;
    logic [DATA_WIDTH-1:0]   w_result_next;
    logic [c_LANE_BITS-1:0]  w_lane_word;

`ifdef STR_OPS_CAESAR_EN
    logic w_unused_b;
    assign w_shift_in = operand_b_i[4:0];
    assign w_unused_b = ^operand_b_i[DATA_WIDTH-1:5];
`else
    logic w_unused_b;
    assign w_shift_in = 5'd0;
    assign w_unused_b = ^operand_b_i;
`endif

    assign ready_o  = (r_state == c_STATE_IDLE) ||
                      ((r_state == c_STATE_DONE) && ex_ready_i);
    assign valid_o  = (r_state == c_STATE_DONE);
    assign result_o = r_result;
    assign w_accept = enable_i && ready_o && !kill_i;

    // Current beat's bytes are shifted down to lane 0 and written back in place.
    assign w_bit_off     = 32'(c_LANE_BITS) * 32'(r_cnt);
    assign w_beat_src    = r_a >> w_bit_off;
    assign w_beat_mask   = DATA_WIDTH'({c_LANE_BITS{1'b1}}) << w_bit_off;
    assign w_beat_data   = DATA_WIDTH'(w_lane_word) << w_bit_off;
    assign w_result_next = (r_result & ~w_beat_mask) | w_beat_data;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            riscv_str_byte_xform u_xform (
                .i_byte  (w_beat_src[gi*8 +: 8]),
                .i_op    (r_op),
                .i_shift (r_shift),
                .o_byte  (w_lane_word[gi*8 +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_STATE_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_a      <= '0;
            r_shift  <= '0;
            r_result <= '0;
        end else if (kill_i) begin
            r_state <= c_STATE_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_STATE_BUSY: begin
                    r_result <= w_result_next;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST_BEAT) begin
                        r_state <= c_STATE_DONE;
                    end
                end
                c_STATE_DONE: begin
                    if (ex_ready_i) begin
                        r_state <= c_STATE_IDLE;
                    end
                end
                default: r_state <= c_STATE_IDLE;
            endcase
            // Accept only happens from IDLE or DONE, so it overrides the above.
            if (w_accept) begin
                r_state <= c_STATE_BUSY;
                r_cnt   <= '0;
                r_op    <= operator_i;
                r_a     <= operand_a_i;
                r_shift <= w_shift_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_str_ops_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_str_ops_unit
// Purpose  : Self-checking bench for riscv_str_ops_unit, LANES=1 and LANES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_str_ops_unit;

    logic        clk = 1'b0;
    logic        rst_s [2];
    logic        en    [2];
    logic [2:0]  opr   [2];
    logic [31:0] opa   [2];
    logic [31:0] opb   [2];
    logic        kill  [2];
    logic        exr   [2];
    logic        rdy   [2];
    logic        vld   [2];
    logic [31:0] res   [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_str_ops_unit #(.DATA_WIDTH(32), .LANES(1)) u_dut1 (
        .clk(clk), .rst(rst_s[0]), .enable_i(en[0]), .operator_i(opr[0]),
        .operand_a_i(opa[0]), .operand_b_i(opb[0]), .kill_i(kill[0]),
        .ex_ready_i(exr[0]), .ready_o(rdy[0]), .valid_o(vld[0]), .result_o(res[0])
    );

    riscv_str_ops_unit #(.DATA_WIDTH(32), .LANES(4)) u_dut4 (
        .clk(clk), .rst(rst_s[1]), .enable_i(en[1]), .operator_i(opr[1]),
        .operand_a_i(opa[1]), .operand_b_i(opb[1]), .kill_i(kill[1]),
        .ex_ready_i(exr[1]), .ready_o(rdy[1]), .valid_o(vld[1]), .result_o(res[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] rot(input logic [7:0] c, input int sh);
        int base;
        if (c >= "A" && c <= "Z")      base = 65;
        else if (c >= "a" && c <= "z") base = 97;
        else return c;
        return 8'(base + ((int'(c) - base + sh) % 26));
    endfunction

    function automatic logic [7:0] ref_byte(input logic [2:0] op, input logic [7:0] c, input int sh);
        logic [7:0] lc;
        lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
        case (op)
            3'd0: return (c >= "a" && c <= "z") ? c - 8'd32 : c;
            3'd1: return lc;
            3'd2: begin
                if (lc == "a") return "4";
                if (lc == "e") return "3";
                if (lc == "i") return "1";
                if (lc == "o") return "0";
                if (lc == "s") return "5";
                if (lc == "t") return "7";
                return c;
            end
            3'd3: return rot(c, 13);
`ifdef STR_OPS_CAESAR_EN
            3'd4: return rot(c, sh % 26);
`endif
            default: return c;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_byte(op, a[8*k +: 8], int'(b[4:0]));
        return w;
    endfunction

    int          beats [2] = '{4, 1};
    int          busy  [2];
    bit          has   [2];
    bit          known [2] = '{1'b0, 1'b0};
    bit          jr    [2];
    logic [31:0] exp_res [2];
    logic [31:0] pend    [2];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    // Compare on negedge, then advance the model by the upcoming posedge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic er;
            er = (busy[i] == 0) && (!has[i] || exr[i]);
            if (known[i]) begin
                chk("ready", i, 32'(rdy[i]), 32'(er));
                chk("valid", i, 32'(vld[i]), 32'(has[i]));
                if (has[i]) chk("result", i, res[i], exp_res[i]);
                if (jr[i])  chk("reset_result", i, res[i], 32'h0);
            end
            if (rst_s[i]) begin
                known[i] = 1'b1; busy[i] = 0; has[i] = 1'b0; jr[i] = 1'b1;
            end else begin
                jr[i] = 1'b0;
                if (kill[i]) begin
                    busy[i] = 0; has[i] = 1'b0;
                end else begin
                    if (busy[i] > 0) begin
                        busy[i]--;
                        if (busy[i] == 0) begin
                            has[i] = 1'b1; exp_res[i] = pend[i];
                        end
                    end else if (has[i] && exr[i]) begin
                        has[i] = 1'b0;
                    end
                    if (en[i] && er) begin
                        busy[i] = beats[i]; has[i] = 1'b0;
                        pend[i] = ref_word(opr[i], opa[i], opb[i]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] edges [8] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h7A, 8'h5A, 8'h61, 8'h41};
        case ($urandom_range(0, 3))
            0:       return 8'(8'h61 + $urandom_range(0, 25));
            1:       return 8'(8'h41 + $urandom_range(0, 25));
            2:       return 8'($urandom_range(0, 255));
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    task automatic txn(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string nm);
        int lat;
        en[i] = 1'b1; opr[i] = op; opa[i] = a; opb[i] = b; exr[i] = 1'b1;
        step();
        en[i] = 1'b0; opa[i] = $urandom;
        lat = 1;
        while (!vld[i] && lat < 40) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, i, 32'(lat), 32'(exp_lat));
        chk({nm, "_value"}, i, res[i], exp);
        step();
    endtask

    task automatic wait_valid(input int i, input string nm);
        int lat;
        lat = 0;
        while (!vld[i] && lat < 40) begin
            step();
            lat++;
        end
        chk({nm, "_reached_done"}, i, 32'(vld[i]), 32'd1);
    endtask

    logic [31:0] c_caesar_exp;

    initial begin
`ifdef STR_OPS_CAESAR_EN
        c_caesar_exp = 32'h44436261;
`else
        c_caesar_exp = 32'h415A7978;
`endif
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; en[i] = 1'b0; opr[i] = 3'd0; opa[i] = 32'h0;
            opb[i] = 32'h0; kill[i] = 1'b0; exr[i] = 1'b1;
        end
        step(); step(); step();
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", i, 32'(rdy[i]), 32'd1);
            chk("reset_valid", i, 32'(vld[i]), 32'd0);
            chk("reset_res", i, res[i], 32'h0);
        end

        txn(0, 3'b000, 32'h6F6C4568, 32'd0,  32'h4F4C4548, 5, "upper");
        txn(0, 3'b011, 32'h2D7A4E61, 32'd0,  32'h2D6D416E, 5, "rot13");
        txn(0, 3'b010, 32'h74736574, 32'd0,  32'h37353337, 5, "leet");
        txn(0, 3'b100, 32'h415A7978, 32'd3,  c_caesar_exp, 5, "caesar3");
        txn(0, 3'b100, 32'h415A7978, 32'd29, c_caesar_exp, 5, "caesar29");
        txn(0, 3'b111, 32'h61417A5A, 32'd7,  32'h61417A5A, 5, "passthru");
        txn(1, 3'b001, 32'h32314241, 32'd0,  32'h32316261, 2, "lower_l4");

        // Back-to-back on the 4-lane unit: DONE and BUSY alternate, no IDLE gap.
        en[1] = 1'b1; opr[1] = 3'b001; exr[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            opa[1] = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
            step();
            chk("b2b_valid", 1, 32'(vld[1]), 32'(c % 2));
        end
        en[1] = 1'b0;
        step();

        // Kill in the second BUSY cycle.
        en[0] = 1'b1; opr[0] = 3'b000; opa[0] = 32'h6F6C4568;
        step(); en[0] = 1'b0;
        step(); kill[0] = 1'b1;
        step(); kill[0] = 1'b0;
        chk("kill_ready", 0, 32'(rdy[0]), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("kill_no_valid", 0, 32'(vld[0]), 32'd0);
            step();
        end

        // Reset in the third BUSY cycle.
        en[0] = 1'b1; opr[0] = 3'b011; opa[0] = 32'h2D7A4E61;
        step(); en[0] = 1'b0;
        step(); step(); rst_s[0] = 1'b1;
        step(); rst_s[0] = 1'b0;
        chk("rst_busy_ready", 0, 32'(rdy[0]), 32'd1);
        chk("rst_busy_res", 0, res[0], 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk("rst_no_valid", 0, 32'(vld[0]), 32'd0);
            step();
        end

        // Kill together with enable must not start an operation.
        en[0] = 1'b1; kill[0] = 1'b1; opa[0] = 32'h61616161;
        step(); en[0] = 1'b0; kill[0] = 1'b0;
        chk("kill_en_ready", 0, 32'(rdy[0]), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("kill_en_no_valid", 0, 32'(vld[0]), 32'd0);
            step();
        end

        // Consumer stalls for 10 cycles in DONE while new requests arrive.
        en[0] = 1'b1; opr[0] = 3'b000; opa[0] = 32'h6F6C4568; exr[0] = 1'b0;
        step(); en[0] = 1'b0;
        wait_valid(0, "stall");
        for (int c = 0; c < 10; c++) begin
            en[0] = 1'b1; opr[0] = 3'($urandom_range(0, 7)); opa[0] = $urandom;
            chk("stall_valid", 0, 32'(vld[0]), 32'd1);
            chk("stall_result", 0, res[0], 32'h4F4C4548);
            chk("stall_ready", 0, 32'(rdy[0]), 32'd0);
            step();
        end
        en[0] = 1'b0; exr[0] = 1'b1;
        step();
        chk("stall_release_valid", 0, 32'(vld[0]), 32'd0);
        chk("stall_release_ready", 0, 32'(rdy[0]), 32'd1);

        // Kill while holding a result drops valid.
        en[0] = 1'b1; opr[0] = 3'b001; opa[0] = 32'h41424344; exr[0] = 1'b0;
        step(); en[0] = 1'b0;
        wait_valid(0, "kill_done");
        kill[0] = 1'b1;
        step(); kill[0] = 1'b0; exr[0] = 1'b1;
        chk("kill_done_valid", 0, 32'(vld[0]), 32'd0);

        // Randomized traffic on both instances.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                rst_s[i] = ($urandom_range(0, 199) == 0);
                kill[i]  = ($urandom_range(0, 39) == 0);
                en[i]    = ($urandom_range(0, 9) < 6);
                exr[i]   = ($urandom_range(0, 9) < 7);
                opr[i]   = 3'($urandom_range(0, 7));
                opa[i]   = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
                opb[i]   = $urandom;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0; kill[i] = 1'b0; en[i] = 1'b0; exr[i] = 1'b1;
        end
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
